qspi_tx_serializer: RTL and testbench
=====================================

Name: qspi_tx_serializer

Overview:
- Read-side consumer of the async FIFO, running in the FIFO read clock domain.
- Pops DATAWIDTH-bit words through the FIFO read port and serialises them onto QSPI IO lanes in single, dual or quad mode, with a programmable SCLK.
- Transfer length is set in bytes. A FIFO underrun stalls SCLK rather than corrupting data.

Parameters:
- DATAWIDTH, 64, FIFO word width; must be a multiple of 8.
- LENW, 16, width of the byte-count input.
- DIVW, 8, width of the SCLK half-period divider.

Ports:
- rclk  in  1  clock, same clock as the FIFO read side.
- rrstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle transfer request; ignored while busy=1.
- xfer_len  in  LENW  transfer length in bytes; latched on start.
- lane_mode  in  2  00 single, 01 dual, 10 quad, 11 treated as single; latched on start.
- clk_div  in  DIVW  SCLK half period = clk_div+1 rclk cycles; latched on start.
- fifo_rdata  in  DATAWIDTH  FIFO read data; first-word-fall-through, valid whenever fifo_rempty=0.
- fifo_rempty  in  1  FIFO empty flag.
- fifo_ren  out  1  FIFO pop strobe.
- sclk  out  1  QSPI serial clock, mode 0 (idles low).
- io_out  out  4  lane data.
- io_oe  out  4  lane output enables.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- underrun  out  1  sticky underrun flag; cleared on an accepted start.

Behaviour:
- Reset values, with rrstn=0 applied asynchronously: state IDLE; sclk=0; io_out=0; io_oe=0; fifo_ren=0; busy=0; done=0; underrun=0; all counters 0.
- Reset mid-transfer: aborts immediately; the FIFO is not drained.
- Symbol width bps is 1, 2 or 4 bits.
  - Total symbols = xfer_len*8/bps; counter width is LENW+3.
  - Symbols per word = DATAWIDTH/bps.
- Bit order: most significant byte of each word first (bits [DATAWIDTH-1:DATAWIDTH-8]), MSB first within each byte.
  - Single: io_out[0] carries the bit; io_oe=0001.
  - Dual: io_out[1:0] carries the symbol, io_out[1] = more significant bit; io_oe=0011.
  - Quad: io_out[3:0] carries the symbol; io_oe=1111.
  - Unused lanes: io_out=0.
- IDLE:
  - busy=0, io_oe=0.
  - On start with xfer_len≠0: latch the inputs, clear underrun, set busy=1, go to LOAD.
  - On start with xfer_len=0: go to DONE without any pop.
- LOAD:
  - fifo_ren = (state==LOAD) & ~fifo_rempty. This is combinational; it is the only path that pops the FIFO.
  - Word available: capture fifo_rdata into the shift register in the same cycle, go to SHIFT. The first symbol appears on io_out in the next cycle with sclk=0.
  - fifo_rempty=1: stay in LOAD with sclk held low, io_out/io_oe held. Set underrun=1 only if at least one symbol of this transfer has already been sent; an empty FIFO before the first word is a plain wait.
- SHIFT:
  - The half-period counter runs clk_div+1 cycles with sclk low, then sclk rises; after another clk_div+1 cycles sclk falls.
  - On each falling edge, decrement the remaining-symbol count.
  - Count reaches 0: go to DONE.
  - Otherwise, if the word is exhausted: go to LOAD.
  - Otherwise: shift out the next symbol in the same cycle as the falling edge.
- DONE: done=1 for one cycle, busy=0, io_oe=0, sclk=0; then IDLE.
- Latency, with start at cycle 0:
  - LOAD at cycle 1 (fifo_ren high if the FIFO is non-empty).
  - io_out valid at cycle 2.
  - First sclk rise at cycle 2+clk_div+1.
- Partial last word: the unused low bytes of the final popped word are discarded.
- The FIFO is never popped beyond ceil(xfer_len*8/DATAWIDTH) words.
- start arriving in the same cycle as done is ignored.

Test Plan:
- Single, clk_div=0, xfer_len=1, word 0xA500_0000_0000_0000 -> io_out[0] = 1,0,1,0,0,1,0,1; 8 sclk rises with a 2-cycle period; one fifo_ren pulse; done one cycle after the 8th fall; underrun=0.
- Quad, clk_div=1, xfer_len=16, words 0x0123456789ABCDEF then 0xFEDCBA9876543210 -> nibbles 0..F then F..0; 32 sclk rises with a 4-cycle period; exactly 2 fifo_ren pulses; io_oe=1111 while busy.
- Dual, xfer_len=3, word 0xC61BE4xx_xxxxxxxx -> symbols 11,00,01,10,00,01,10,11,11,10,01,00; 12 rises; one pop; remaining 5 bytes dropped.
- Single, xfer_len=9, only one word queued -> after 64 bits sclk stays low, busy=1, underrun=1. Then push 0xFF00_0000_0000_0000 -> resumes, 8 ones, done; underrun remains 1 until the next start.
- xfer_len=0 -> done at cycle 1 with no fifo_ren. Also, start while busy -> ignored; the transfer is unchanged.
- Deassert rrstn mid-transfer in quad mode -> sclk, io_oe, busy and fifo_ren go to 0 immediately; a new start afterwards transfers correctly from the next FIFO word.

Source files
------------

// File: rtl/qspi_tx_serializer.sv
// QSPI transmit serializer: pops FIFO words and shifts them MSB-first onto 1/2/4 IO lanes.
// Latency: start -> LOAD next cycle, first symbol on io_out one cycle later, first SCLK rise clk_div+1 cycles after that.
// Backpressure: an empty FIFO parks the FSM in LOAD with SCLK low; data is never skipped or repeated.
module qspi_tx_serializer #(
  parameter int DATAWIDTH = 64,
  parameter int LENW      = 16,
  parameter int DIVW      = 8
) (
  input  logic                 rclk,
  input  logic                 rrstn,
  input  logic                 start,
  input  logic [LENW-1:0]      xfer_len,
  input  logic [1:0]           lane_mode,
  input  logic [DIVW-1:0]      clk_div,
  input  logic [DATAWIDTH-1:0] fifo_rdata,
  input  logic                 fifo_rempty,
  output logic                 fifo_ren,
  output logic                 sclk,
  output logic [3:0]           io_out,
  output logic [3:0]           io_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  localparam int CNTW = LENW + 3;
  localparam int WCW  = $clog2(DATAWIDTH + 1);
  localparam logic [CNTW-1:0] SYM_ONE  = CNTW'(1);
  localparam logic [WCW-1:0]  WRD_ONE  = WCW'(1);
  localparam logic [WCW-1:0]  WRD_BITS = WCW'(DATAWIDTH);
  localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           shift_q;      // log2 of bits per symbol
  logic [DIVW-1:0]      div_q;
  logic [DIVW-1:0]      hcnt_q;
  logic                 sclk_q;
  logic [DATAWIDTH-1:0] shreg_q;
  logic [CNTW-1:0]      sym_left_q;
  logic [WCW-1:0]       word_left_q;
  logic [3:0]           oe_q;
  logic                 underrun_q;
  logic                 popped_q;     // a word of this transfer has been consumed

  // Mode 11 falls back to single-lane operation.
  function automatic logic [1:0] mode_to_shift(input logic [1:0] mode);
    case (mode)
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] shift_to_mask(input logic [1:0] s);
    case (s)
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  logic [1:0] start_shift;
  logic [2:0] bps;
  logic       half_done;
  logic       sclk_fall;
  logic       last_sym;
  logic       last_in_word;
  logic [3:0] sym;

  assign start_shift  = mode_to_shift(lane_mode);
  assign bps          = 3'd1 << shift_q;
  assign half_done    = (hcnt_q == div_q);
  assign sclk_fall    = (state_q == S_SHIFT) && sclk_q && half_done;
  assign last_sym     = (sym_left_q == SYM_ONE);
  assign last_in_word = (word_left_q == WRD_ONE);

  // State register.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE, so a start coincident with done is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (xfer_len == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (!fifo_rempty) state_d = S_SHIFT;
      S_SHIFT: if (sclk_fall) begin
                 if (last_sym)          state_d = S_DONE;
                 else if (last_in_word) state_d = S_LOAD;
               end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-decoded outputs; the pop strobe is combinational so the FWFT word is captured in the same cycle.
  always_comb begin
    fifo_ren = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_LOAD:  begin fifo_ren = ~fifo_rempty; busy = 1'b1; end
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: parameter latch, word capture, SCLK half-period timing and symbol shifting.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      shift_q     <= '0;
      div_q       <= '0;
      hcnt_q      <= '0;
      sclk_q      <= 1'b0;
      shreg_q     <= '0;
      sym_left_q  <= '0;
      word_left_q <= '0;
      oe_q        <= '0;
      underrun_q  <= 1'b0;
      popped_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          underrun_q <= 1'b0;
          if (xfer_len != '0) begin
            shift_q    <= start_shift;
            div_q      <= clk_div;
            sym_left_q <= {xfer_len, 3'b000} >> start_shift;
            hcnt_q     <= '0;
            sclk_q     <= 1'b0;
            shreg_q    <= '0;
            popped_q   <= 1'b0;
            oe_q       <= shift_to_mask(start_shift);
          end
        end
        S_LOAD: begin
          if (!fifo_rempty) begin
            shreg_q     <= fifo_rdata;
            word_left_q <= WRD_BITS >> shift_q;
            hcnt_q      <= '0;
            sclk_q      <= 1'b0;
            popped_q    <= 1'b1;
          end else if (popped_q) begin
            // Starved mid-transfer; waiting for the very first word is not an underrun.
            underrun_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (half_done) begin
            hcnt_q <= '0;
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
              sym_left_q <= sym_left_q - SYM_ONE;
              if (last_sym) begin
                oe_q <= '0;
              end else if (!last_in_word) begin
                shreg_q     <= shreg_q << bps;
                word_left_q <= word_left_q - WRD_ONE;
              end
            end
          end else begin
            hcnt_q <= hcnt_q + DIV_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Current symbol from the top of the shift register; unused lanes are driven low.
  always_comb begin
    case (shift_q)
      2'd1:    sym = {2'b00, shreg_q[DATAWIDTH-1 -: 2]};
      2'd2:    sym = shreg_q[DATAWIDTH-1 -: 4];
      default: sym = {3'b000, shreg_q[DATAWIDTH-1]};
    endcase
  end

  assign io_out   = sym & oe_q;
  assign io_oe    = oe_q;
  assign sclk     = sclk_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_qspi_tx_serializer.sv
// Testbench for qspi_tx_serializer: directed plus randomized transfers against a byte-level model.
// FIFO is modelled as a FWFT word array popped on fifo_ren at the rising edge.
// Outputs are sampled on the falling edge; symbols are captured at each SCLK rise.
module tb_qspi_tx_serializer;
  localparam int DW = 64, LENW = 16, DIVW = 8;

  logic            rclk = 1'b0;
  logic            rrstn = 1'b0;
  logic            start = 1'b0;
  logic [LENW-1:0] xfer_len = '0;
  logic [1:0]      lane_mode = '0;
  logic [DIVW-1:0] clk_div = '0;
  logic [DW-1:0]   fifo_rdata;
  logic            fifo_rempty;
  logic            fifo_ren, sclk, busy, done, underrun;
  logic [3:0]      io_out, io_oe;

  qspi_tx_serializer #(.DATAWIDTH(DW), .LENW(LENW), .DIVW(DIVW)) dut (
    .rclk(rclk), .rrstn(rrstn), .start(start), .xfer_len(xfer_len),
    .lane_mode(lane_mode), .clk_div(clk_div), .fifo_rdata(fifo_rdata),
    .fifo_rempty(fifo_rempty), .fifo_ren(fifo_ren), .sclk(sclk),
    .io_out(io_out), .io_oe(io_oe), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 rclk = ~rclk;

  // FIFO model
  logic [63:0] mem [0:127];
  int wr_ptr = 0, rd_ptr = 0;
  assign fifo_rempty = (wr_ptr == rd_ptr);
  assign fifo_rdata  = mem[rd_ptr[6:0]];
  always @(posedge rclk) if (fifo_ren === 1'b1) rd_ptr <= rd_ptr + 1;

  // Monitor
  int          cyc = 0;
  logic        sclk_prev = 1'b0;
  logic [3:0]  rs_sym[$];
  logic [3:0]  rs_oe[$];
  int          rs_cyc[$];
  int          pop_cyc[$];
  int          done_cyc[$];
  int          oe_bad = 0;
  logic [3:0]  cur_mask = 4'b0001;
  always @(negedge rclk) begin
    cyc++;
    if (sclk === 1'b1 && sclk_prev === 1'b0) begin
      rs_sym.push_back(io_out);
      rs_oe.push_back(io_oe);
      rs_cyc.push_back(cyc);
    end
    if (fifo_ren === 1'b1) pop_cyc.push_back(cyc);
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (busy === 1'b1 && io_oe !== cur_mask) oe_bad++;
    sclk_prev = sclk;
  end

  int checks = 0, errors = 0;
  int t0, rb, pb, db, ob;
  logic [63:0] cur_words[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mask_of(input int mode);
    return (mode == 1) ? 4'b0011 : (mode == 2) ? 4'b1111 : 4'b0001;
  endfunction

  task automatic push_word(input logic [63:0] w);
    mem[wr_ptr[6:0]] = w;
    wr_ptr = wr_ptr + 1;
    cur_words.push_back(w);
  endtask

  task automatic kick(input int len, input int mode, input int div);
    cur_mask = mask_of(mode);
    @(posedge rclk); #1;
    xfer_len = LENW'(len); lane_mode = 2'(mode); clk_div = DIVW'(div);
    start = 1'b1;
    t0 = cyc; rb = rs_sym.size(); pb = pop_cyc.size(); db = done_cyc.size(); ob = oe_bad;
    @(posedge rclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cyc.size() == db && n < budget) begin
      @(posedge rclk);
      n++;
    end
    repeat (3) @(posedge rclk);
    #1;
    check({tag, "-done_count"}, done_cyc.size() - db, 1);
  endtask

  task automatic wait_rises(input int cnt, input int budget);
    int n = 0;
    while ((rs_sym.size() - rb) < cnt && n < budget) begin
      @(posedge rclk);
      n++;
    end
  endtask

  // Byte-level reference: bytes taken MSB-first from each word, each byte split MSB-first into symbols.
  task automatic verify(input string tag, input int len, input int mode, input logic exp_unr);
    logic [3:0]  exp_q[$];
    logic [63:0] w;
    logic [7:0]  b;
    int          bps;
    bps = (mode == 1) ? 2 : (mode == 2) ? 4 : 1;
    for (int i = 0; i < len; i++) begin
      w = cur_words[i / 8];
      b = w[63 - 8 * (i % 8) -: 8];
      for (int s = 0; s < 8 / bps; s++)
        exp_q.push_back(4'((b >> (8 - bps * (s + 1))) & ((1 << bps) - 1)));
    end
    check({tag, "-rises"}, rs_sym.size() - rb, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (rb + k < rs_sym.size()) begin
        check($sformatf("%s-sym%0d", tag, k), rs_sym[rb + k], exp_q[k]);
        check($sformatf("%s-oe%0d", tag, k), rs_oe[rb + k], mask_of(mode));
      end
    end
    check({tag, "-pops"}, pop_cyc.size() - pb, (len + 7) / 8);
    check({tag, "-oe_while_busy"}, oe_bad - ob, 0);
    check({tag, "-underrun"}, underrun, exp_unr);
    check({tag, "-busy_after"}, busy, 1'b0);
    check({tag, "-sclk_after"}, sclk, 1'b0);
  endtask

  initial begin
    int mode, div, len, nw;
    logic [63:0] w1, w2;

    // Reset state
    #2;
    check("rst-sclk", sclk, 1'b0);
    check("rst-io_out", io_out, 4'h0);
    check("rst-io_oe", io_oe, 4'h0);
    check("rst-fifo_ren", fifo_ren, 1'b0);
    check("rst-busy", busy, 1'b0);
    check("rst-done", done, 1'b0);
    check("rst-underrun", underrun, 1'b0);
    #20 rrstn = 1'b1;

    // Single lane, one byte, fastest SCLK
    cur_words = {};
    push_word(64'hA500_0000_0000_0000);
    kick(1, 0, 0);
    wait_done("t1", 200);
    verify("t1", 1, 0, 1'b0);
    check("t1-has_pop", pop_cyc.size() > pb, 1'b1);
    if (pop_cyc.size() > pb) check("t1-pop_cycle", pop_cyc[pb] - t0 - 1, 1);
    check("t1-has_rise", rs_cyc.size() > rb, 1'b1);
    if (rs_cyc.size() > rb) check("t1-first_rise_cycle", rs_cyc[rb] - t0 - 1, 3);
    for (int k = 0; k < 7; k++)
      if (rb + k + 1 < rs_cyc.size()) check($sformatf("t1-period%0d", k), rs_cyc[rb + k + 1] - rs_cyc[rb + k], 2);

    // Quad, two words, with an ignored start while busy
    cur_words = {};
    push_word(64'h0123_4567_89AB_CDEF);
    push_word(64'hFEDC_BA98_7654_3210);
    kick(16, 2, 1);
    repeat (12) @(posedge rclk);
    #1;
    check("t2-busy_mid", busy, 1'b1);
    xfer_len = 16'd1; lane_mode = 2'b00; clk_div = 8'd0; start = 1'b1;
    @(posedge rclk); #1;
    start = 1'b0;
    wait_done("t2", 400);
    verify("t2", 16, 2, 1'b0);
    if (rs_cyc.size() > rb) check("t2-first_rise_cycle", rs_cyc[rb] - t0 - 1, 4);
    for (int k = 0; k < 15; k++)
      if (rb + k + 1 < rs_cyc.size()) check($sformatf("t2-period%0d", k), rs_cyc[rb + k + 1] - rs_cyc[rb + k], 4);

    // Dual, partial word: low five bytes discarded
    cur_words = {};
    push_word(64'hC61B_E45A_5A5A_5A5A);
    kick(3, 1, $urandom_range(0, 2));
    wait_done("t3", 400);
    verify("t3", 3, 1, 1'b0);
    check("t3-fifo_empty", fifo_rempty, 1'b1);

    // Underrun: nine bytes but only one word queued
    cur_words = {};
    push_word({$urandom, $urandom});
    kick(9, 0, 0);
    wait_rises(64, 1000);
    repeat (10) @(posedge rclk);
    #1;
    check("t4-stall_rises", rs_sym.size() - rb, 64);
    check("t4-stall_busy", busy, 1'b1);
    check("t4-stall_sclk", sclk, 1'b0);
    check("t4-stall_underrun", underrun, 1'b1);
    check("t4-stall_ren", fifo_ren, 1'b0);
    push_word(64'hFF00_0000_0000_0000);
    wait_done("t4", 400);
    verify("t4", 9, 0, 1'b1);

    // Empty FIFO before the first word is a plain wait; start clears underrun
    cur_words = {};
    kick(2, 2, 0);
    repeat (6) @(posedge rclk);
    #1;
    check("t5-wait_underrun", underrun, 1'b0);
    check("t5-wait_busy", busy, 1'b1);
    check("t5-wait_sclk", sclk, 1'b0);
    push_word({$urandom, $urandom});
    wait_done("t5", 400);
    verify("t5", 2, 2, 1'b0);

    // Zero-length transfer
    cur_words = {};
    kick(0, 0, 3);
    wait_done("t6", 50);
    if (done_cyc.size() > db) check("t6-done_cycle", done_cyc[db] - t0 - 1, 1);
    verify("t6", 0, 0, 1'b0);

    // Reset mid-transfer in quad mode, then resume from the next FIFO word
    cur_words = {};
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    push_word(w1);
    push_word(w2);
    kick(16, 2, 1);
    wait_rises(5, 500);
    @(posedge rclk);
    #3 rrstn = 1'b0;
    #1;
    check("t7-rst_sclk", sclk, 1'b0);
    check("t7-rst_io_oe", io_oe, 4'h0);
    check("t7-rst_busy", busy, 1'b0);
    check("t7-rst_ren", fifo_ren, 1'b0);
    check("t7-rst_io_out", io_out, 4'h0);
    #10 rrstn = 1'b1;
    check("t7-fifo_not_drained", wr_ptr - rd_ptr, 1);
    cur_words = {};
    cur_words.push_back(w2);
    kick(8, 2, 0);
    wait_done("t7b", 400);
    verify("t7b", 8, 2, 1'b0);

    // Randomized transfers
    for (int r = 0; r < 6; r++) begin
      mode = $urandom_range(0, 3);
      div  = $urandom_range(0, 3);
      len  = $urandom_range(1, 24);
      nw   = (len + 7) / 8;
      cur_words = {};
      for (int i = 0; i < nw; i++) push_word({$urandom, $urandom});
      kick(len, mode, div);
      wait_done($sformatf("rnd%0d", r), 8000);
      verify($sformatf("rnd%0d", r), len, mode, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
